acc_master: RTL and testbench
=============================

// Module: acc_master
// PURPOSE
//  Hardware initiator for the accumulator (acc) interface: drives a, b, accumulate, acc_en_n and reads back y.
//  Accepts operations on a valid/ready request stream, runs each one on acc, returns y on a valid/ready response stream.
//  Sits between a stream producer and the acc instance; replaces the bench-side driver in system-level use.
// PARAMETERS
//  DATA_WIDTH  8   operand/result width; must match the acc instance (acc_pkg::DATA_WIDTH)
//  CNT_WIDTH   16  width of the completed-operation counter op_cnt
// PORTS
//  clk             in   1           clock, rising edge
//  rst_n           in   1           asynchronous reset, active-low
//  req_valid       in   1           request present
//  req_ready       out  1           request accepted when req_valid & req_ready at posedge
//  req_a           in   DATA_WIDTH  operand a
//  req_b           in   DATA_WIDTH  operand b
//  req_acc         in   1           1: accumulate onto previous y; 0: load a+b
//  rsp_valid       out  1           response present
//  rsp_ready       in   1           response consumed when rsp_valid & rsp_ready at posedge
//  rsp_y           out  DATA_WIDTH  result
//  acc_a/acc_b     out  DATA_WIDTH  to acc a/b
//  acc_accumulate  out  1           to acc accumulate
//  acc_en_n        out  1           to acc acc_en_n, active-low enable
//  acc_y           in   DATA_WIDTH  from acc y
//  op_cnt          out  CNT_WIDTH   number of completed responses, wraps at 2^CNT_WIDTH
//  err             out  1           sticky self-check mismatch flag (see CONFIGURATION)
// BEHAVIOUR
//  acc contract: at posedge with acc_en_n=0, y <= b + (accumulate ? y : a) mod 2^DATA_WIDTH; otherwise y holds; reset y=0.
//  Reset values: req_ready=1, rsp_valid=0, rsp_y=0, acc_a=acc_b=0, acc_accumulate=0, acc_en_n=1, op_cnt=0, err=0; state IDLE.
//  FSM:
//    IDLE  req_ready=1. On request handshake: register req_a/b/acc onto acc_a/b/acc_accumulate; go to EXEC.
//    EXEC  acc_en_n=0 for exactly this one cycle; acc samples at the closing edge; go to CAPT.
//    CAPT  acc_en_n=1. At the closing edge: rsp_y<=acc_y, rsp_valid<=1, op_cnt++; go to RESP.
//    RESP  rsp_valid=1; rsp_y stable. req_ready=rsp_ready.
//          On rsp_ready, with no req_valid: rsp_valid<=0, go to IDLE.
//          On rsp_ready with req_valid: accept the new request in the same edge and go to EXEC (back-to-back).
//  Latency: request handshake at edge E0, acc enabled at E1, rsp_valid=1 after E2.
//  Throughput: one operation per 3 cycles with rsp_ready held at 1.
//  acc_a/acc_b/acc_accumulate hold their last issued values outside EXEC. acc_en_n is never low in IDLE/CAPT/RESP.
//  req_ready is 0 in EXEC/CAPT and in RESP while rsp_ready=0; a pending req_valid waits, with no loss or duplication.
//  Backpressure: rsp_ready=0 in RESP holds rsp_valid and rsp_y unchanged indefinitely; acc is not re-enabled.
//  Arithmetic is mod 2^DATA_WIDTH; no overflow flag. op_cnt wraps from all-ones to 0.
//  req_acc=1 as the first operation after reset accumulates onto y=0.
//  Reset mid-operation (any state): immediately return to reset values. The in-flight request is dropped and gives no response.
//  rst_n is shared with acc, so acc's y is also cleared.
// CONFIGURATION
//  ACC_MASTER_CHECK_EN defined:
//    - Shadow register exp, reset 0; updated at the EXEC closing edge with the acc contract formula.
//    - In CAPT, acc_y != exp sets err=1 at the closing edge. err is sticky until reset; the response is still delivered.
//  ACC_MASTER_CHECK_EN undefined: no shadow logic; err tied to 0; the port list is unchanged.
// TESTING (DATA_WIDTH=8)
//  Reset: assert rst_n=0 -> all outputs at reset values; acc_en_n=1, req_ready=1.
//  Load/accumulate: a=3,b=4,acc=0 -> rsp_y=7 two edges after accept; then acc=1,b=5 -> rsp_y=12; op_cnt=2.
//  Wrap: a=250,b=10,acc=0 -> rsp_y=4; op_cnt preloaded to 16'hFFFF by 65535 ops, or forced -> 0 after the next response.
//  Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid=1 and rsp_y stable, req_ready=0, acc_en_n=1, acc_y unchanged.
//  Streaming: req_valid=1 and rsp_ready=1 for 10 ops with b=1,acc=1 -> acc_en_n pulses once every 3 cycles; rsp_y=1..10.
//  Reset during EXEC -> next cycle IDLE, rsp_valid=0, no response emitted.
//  With ACC_MASTER_CHECK_EN: force acc_y wrong in CAPT -> err=1 and stays 1.

Source files
------------

// File: rtl/acc_master_if.sv
// Bundle of request/response stream and acc drive signals for acc_master.
// Handshake: a transfer happens at a rising clk edge where valid & ready are both 1; valid never waits on ready.
interface acc_master_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] req_a;
  logic [DATA_WIDTH-1:0] req_b;
  logic                  req_acc;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_y;
  logic [DATA_WIDTH-1:0] acc_a;
  logic [DATA_WIDTH-1:0] acc_b;
  logic                  acc_accumulate;
  logic                  acc_en_n;
  logic [DATA_WIDTH-1:0] acc_y;
  logic [CNT_WIDTH-1:0]  op_cnt;
  logic                  err;

  modport master (
    input  req_valid, req_a, req_b, req_acc, rsp_ready, acc_y,
    output req_ready, rsp_valid, rsp_y, acc_a, acc_b, acc_accumulate, acc_en_n, op_cnt, err
  );

  modport slave (
    output req_valid, req_a, req_b, req_acc, rsp_ready, acc_y,
    input  req_ready, rsp_valid, rsp_y, acc_a, acc_b, acc_accumulate, acc_en_n, op_cnt, err
  );
endinterface

// File: rtl/acc_master.sv
// Stream-to-acc initiator: issues each request to acc as one enable pulse and returns y as a response.
// Optional ACC_MASTER_CHECK_EN adds a shadow accumulator that flags a sticky err on acc_y mismatch.
module acc_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  acc_master_if.master      bus,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  accum_q, accum_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  req_ready;
  logic                  accept;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    accum_d     = accum_q;
    y_d         = y_q;
    rsp_valid_d = rsp_valid_q;
    cnt_d       = cnt_q;
    req_ready   = 1'b0;
    accept      = 1'b0;

    case (state_q)
      IDLE: req_ready = 1'b1;
      RESP: req_ready = bus.rsp_ready;
      default: req_ready = 1'b0;
    endcase
    accept = bus.req_valid && req_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          accum_d = bus.req_acc;
          state_d = EXEC;
        end
      end
      EXEC: state_d = CAPT;
      CAPT: begin
        y_d         = bus.acc_y;
        rsp_valid_d = 1'b1;
        cnt_d       = cnt_q + CNT_WIDTH'(1);
        state_d     = RESP;
      end
      RESP: begin
        // A consumed response may be overlapped with the next request in the same edge.
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (accept) begin
            a_d     = bus.req_a;
            b_d     = bus.req_b;
            accum_d = bus.req_acc;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      accum_q     <= 1'b0;
      y_q         <= '0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      accum_q     <= accum_d;
      y_q         <= y_d;
      rsp_valid_q <= rsp_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.req_ready      = req_ready;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_y          = y_q;
  assign bus.acc_a          = a_q;
  assign bus.acc_b          = b_q;
  assign bus.acc_accumulate = accum_q;
  assign bus.acc_en_n       = (state_q != EXEC);
  assign bus.op_cnt         = cnt_q;
  assign state_o            = state_q;

`ifdef ACC_MASTER_CHECK_EN
  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic                  err_q, err_d;

  // Shadow tracks what acc must hold after each enable; compared while acc_y is settled in CAPT.
  always_comb begin
    shadow_d = shadow_q;
    err_d    = err_q;
    if (state_q == EXEC) begin
      shadow_d = b_q + (accum_q ? shadow_q : a_q);
    end
    if ((state_q == CAPT) && (bus.acc_y != shadow_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_acc_master.sv
// Self-checking bench for acc_master: behavioural acc device, request-level reference model, response scoreboard.
module tb_acc_master;
  localparam int DW    = 8;
  localparam int CNT_W = 5;

  logic clk;
  logic rst_n;
  logic [1:0] state_dbg;

  acc_master_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CNT_W)) bus ();

  acc_master #(.DATA_WIDTH(DW), .CNT_WIDTH(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // behavioural acc device
  logic [DW-1:0] acc_y_q;
  logic [DW-1:0] corrupt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_y_q <= '0;
    else if (!bus.acc_en_n) acc_y_q <= bus.acc_b + (bus.acc_accumulate ? acc_y_q : bus.acc_a);
  end
  assign bus.acc_y = acc_y_q ^ corrupt;

  // scoreboard and reference model
  int n_checks;
  int n_fail;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] y_ref;
  int            mcnt;
  logic [DW-1:0] last_rsp;
  int            cyc;
  int            en_q[$];
  logic          rec_en;
  logic          bp_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && rec_en && !bus.acc_en_n) en_q.push_back(cyc);
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        last_rsp = bus.rsp_y;
        check("rsp_y", bus.rsp_y, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    y_ref = '0;
    mcnt  = 0;
  endtask

  task automatic push_req(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic acc);
    bit ok;
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_acc   = acc;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    bus.req_valid = 1'b0;
    if (ok) begin
      y_ref = acc ? y_ref + b : a + b;
      exp_q.push_back(y_ref ^ corrupt);
      mcnt++;
    end else begin
      check("req_accept_timeout", 32'(ok), 32'd1);
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  task automatic check_cnt(input string tag);
    check(tag, bus.op_cnt, 32'(mcnt % (1 << CNT_W)));
  endtask

  logic [DW-1:0] held_y, held_acc_y;

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; rec_en = 1'b0; corrupt = '0; bp_done = 1'b0;
    last_rsp = '0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_acc = 1'b0;
    bus.rsp_ready = 1'b0;
    model_reset();

    // reset values
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_y", bus.rsp_y, 0);
    check("rst_acc_a", bus.acc_a, 0);
    check("rst_acc_b", bus.acc_b, 0);
    check("rst_acc_accum", bus.acc_accumulate, 0);
    check("rst_acc_en_n", bus.acc_en_n, 1);
    check("rst_op_cnt", bus.op_cnt, 0);
    check("rst_err", bus.err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // load then accumulate, with latency checks on the first op
    push_req(8'd3, 8'd4, 1'b0);
    @(negedge clk);
    check("lat_exec_en_n", bus.acc_en_n, 0);
    check("lat_exec_valid", bus.rsp_valid, 0);
    @(negedge clk);
    check("lat_capt_en_n", bus.acc_en_n, 1);
    check("lat_capt_valid", bus.rsp_valid, 0);
    @(negedge clk);
    check("lat_resp_valid", bus.rsp_valid, 1);
    check("lat_resp_y", bus.rsp_y, 7);
    tick();
    bus.rsp_ready = 1'b1;
    wait_drain();
    push_req(8'd0, 8'd5, 1'b1);
    wait_drain();
    check("accum_y", last_rsp, 12);
    check_cnt("op_cnt_two");

    // backpressure
    bus.rsp_ready = 1'b0;
    push_req(DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    check("bp_valid_rise", bus.rsp_valid, 1);
    held_y     = bus.rsp_y;
    held_acc_y = bus.acc_y;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_valid", bus.rsp_valid, 1);
      check("bp_rsp_y", bus.rsp_y, held_y);
      check("bp_req_ready", bus.req_ready, 0);
      check("bp_acc_en_n", bus.acc_en_n, 1);
      check("bp_acc_y", bus.acc_y, held_acc_y);
    end
    tick();
    bus.rsp_ready = 1'b1;
    wait_drain();
    check_cnt("op_cnt_bp");

    // reset while the request is executing
    push_req(8'd9, 8'd9, 1'b0);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check("rstx_rsp_valid", bus.rsp_valid, 0);
    check("rstx_req_ready", bus.req_ready, 1);
    check("rstx_acc_en_n", bus.acc_en_n, 1);
    check("rstx_op_cnt", bus.op_cnt, 0);
    check("rstx_acc_y", bus.acc_y, 0);
    tick();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rstx_no_rsp", bus.rsp_valid, 0);
    tick();

    // streaming: b=1 accumulate, rsp_ready held high
    en_q.delete();
    rec_en = 1'b1;
    for (int i = 0; i < 10; i++) push_req(DW'($urandom_range(0, 255)), 8'd1, 1'b1);
    wait_drain();
    rec_en = 1'b0;
    check("stream_last_y", last_rsp, 10);
    check("stream_en_pulses", 32'(en_q.size()), 10);
    for (int i = 1; i < en_q.size(); i++) check("stream_en_spacing", 32'(en_q[i] - en_q[i-1]), 3);
    check_cnt("op_cnt_stream");

    // random operands with random response backpressure
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 21; i++)
          push_req(DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk);
          #1;
          bus.rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.rsp_ready = 1'b1;
    wait_drain();
    check("op_cnt_all_ones", bus.op_cnt, (1 << CNT_W) - 1);

    // operand wrap and counter wrap
    push_req(8'd250, 8'd10, 1'b0);
    wait_drain();
    check("wrap_y", last_rsp, 4);
    check("op_cnt_wrap", bus.op_cnt, 0);

`ifdef ACC_MASTER_CHECK_EN
    check("err_before", bus.err, 0);
    corrupt = 8'h01;
    push_req(DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)), 1'b0);
    wait_drain();
    corrupt = '0;
    check("err_set", bus.err, 1);
    push_req(8'd1, 8'd2, 1'b0);
    wait_drain();
    check("err_sticky", bus.err, 1);
`else
    check("err_tied", bus.err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
